// File: rtl/butterfly_pkg.sv
// Shared types and arithmetic helpers for the radix-2 FFT butterfly.
// Operands are packed complex words: real half on top, imaginary below.
package butterfly_pkg;

    localparam int WIDTH   = 36;
    localparam int HALF_W  = WIDTH / 2;
    localparam int TW_FRAC = HALF_W - 1;
    localparam int PROD_W  = 2 * HALF_W + 1;

    typedef struct packed {
        logic signed [HALF_W-1:0] re;
        logic signed [HALF_W-1:0] im;
    } cplx_t;

    localparam logic signed [PROD_W-1:0] SAT_MAX =
        {{(PROD_W-HALF_W+1){1'b0}}, {(HALF_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        {{(PROD_W-HALF_W+1){1'b1}}, {(HALF_W-1){1'b0}}};
    localparam logic signed [PROD_W-1:0] RND_HALF =
        {{(PROD_W-TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC-1){1'b0}}};

    function automatic logic signed [HALF_W-1:0] sat18(
        input logic signed [PROD_W-1:0] x
    );
        logic signed [HALF_W-1:0] r;
        if (x > SAT_MAX) begin
            r = SAT_MAX[HALF_W-1:0];
        end else if (x < SAT_MIN) begin
            r = SAT_MIN[HALF_W-1:0];
        end else begin
            r = x[HALF_W-1:0];
        end
        return r;
    endfunction

    // Half-up: ties go toward +inf, so -0.5 rounds to 0.
    function automatic logic signed [PROD_W-1:0] rnd_shift(
        input logic signed [PROD_W-1:0] x
    );
        logic signed [PROD_W-1:0] t;
        t = x + RND_HALF;
        return t >>> TW_FRAC;
    endfunction

endpackage

// File: rtl/butterfly_unit_if.sv
// Operand/result bundle between the FFT stage and one butterfly lane.
// No backpressure: the producer simply flags each operand set valid.
import butterfly_pkg::*;

interface butterfly_unit_if;

    logic             in_valid;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] twiddle_in;
    logic             out_valid;
    logic [WIDTH-1:0] sum_out;
    logic [WIDTH-1:0] diff_out;

    modport master (
        output in_valid,
        output a_in,
        output b_in,
        output twiddle_in,
        input  out_valid,
        input  sum_out,
        input  diff_out
    );

    modport slave (
        input  in_valid,
        input  a_in,
        input  b_in,
        input  twiddle_in,
        output out_valid,
        output sum_out,
        output diff_out
    );

endinterface

// File: rtl/butterfly_unit_complex_mult.sv
// Registered complex multiply P = W*B with Q1.17 twiddle,
// half-up rounding and 18-bit saturation of each component.
import butterfly_pkg::*;

module complex_mult (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  valid_i,
    input  cplx_t b_i,
    input  cplx_t w_i,
    output logic  valid_o,
    output cplx_t p_o
);

    logic signed [2*HALF_W-1:0] br_x;
    logic signed [2*HALF_W-1:0] bi_x;
    logic signed [2*HALF_W-1:0] wr_x;
    logic signed [2*HALF_W-1:0] wi_x;
    logic signed [2*HALF_W-1:0] p_rr;
    logic signed [2*HALF_W-1:0] p_ii;
    logic signed [2*HALF_W-1:0] p_ri;
    logic signed [2*HALF_W-1:0] p_ir;
    logic signed [PROD_W-1:0]   re_full;
    logic signed [PROD_W-1:0]   im_full;
    cplx_t                      p_d;
    cplx_t                      p_q;
    logic                       valid_q;

    // Operands widened first so each product is a plain 18x18 signed.
    always_comb begin
        br_x    = {{HALF_W{b_i.re[HALF_W-1]}}, b_i.re};
        bi_x    = {{HALF_W{b_i.im[HALF_W-1]}}, b_i.im};
        wr_x    = {{HALF_W{w_i.re[HALF_W-1]}}, w_i.re};
        wi_x    = {{HALF_W{w_i.im[HALF_W-1]}}, w_i.im};
        p_rr    = br_x * wr_x;
        p_ii    = bi_x * wi_x;
        p_ri    = br_x * wi_x;
        p_ir    = bi_x * wr_x;
        re_full = {p_rr[2*HALF_W-1], p_rr}
                - {p_ii[2*HALF_W-1], p_ii};
        im_full = {p_ri[2*HALF_W-1], p_ri}
                + {p_ir[2*HALF_W-1], p_ir};
        p_d.re  = sat18(rnd_shift(re_full));
        p_d.im  = sat18(rnd_shift(im_full));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            p_q     <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                p_q <= p_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign p_o     = p_q;

endmodule

// File: rtl/butterfly_unit.sv
// Radix-2 DIT butterfly lane: sum = A + W*B, diff = A - W*B.
// Three register stages: capture, complex multiply, add/subtract.
import butterfly_pkg::*;

module butterfly_unit (
    input  logic                  clk,
    input  logic                  rst_n,
    butterfly_unit_if.slave       bus
);

    cplx_t                    a1_q;
    cplx_t                    b1_q;
    cplx_t                    w1_q;
    logic                     v1_q;
    cplx_t                    a2_q;
    cplx_t                    p2;
    logic                     v2;
    cplx_t                    sum_d;
    cplx_t                    diff_d;
    cplx_t                    sum_q;
    cplx_t                    diff_q;
    logic                     v3_q;
    logic signed [HALF_W:0]   sr;
    logic signed [HALF_W:0]   si;
    logic signed [HALF_W:0]   dr;
    logic signed [HALF_W:0]   di;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            a1_q <= '0;
            b1_q <= '0;
            w1_q <= '0;
        end else begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                a1_q <= bus.a_in;
                b1_q <= bus.b_in;
                w1_q <= bus.twiddle_in;
            end
        end
    end

    complex_mult u_cmul (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (v1_q),
        .b_i     (b1_q),
        .w_i     (w1_q),
        .valid_o (v2),
        .p_o     (p2)
    );

    // A rides one stage beside the multiplier to stay aligned with P.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a2_q <= '0;
        end else if (v1_q) begin
            a2_q <= a1_q;
        end
    end

    always_comb begin
        sr        = {a2_q.re[HALF_W-1], a2_q.re}
                  + {p2.re[HALF_W-1], p2.re};
        si        = {a2_q.im[HALF_W-1], a2_q.im}
                  + {p2.im[HALF_W-1], p2.im};
        dr        = {a2_q.re[HALF_W-1], a2_q.re}
                  - {p2.re[HALF_W-1], p2.re};
        di        = {a2_q.im[HALF_W-1], a2_q.im}
                  - {p2.im[HALF_W-1], p2.im};
        sum_d.re  = sat18(PROD_W'(sr));
        sum_d.im  = sat18(PROD_W'(si));
        diff_d.re = sat18(PROD_W'(dr));
        diff_d.im = sat18(PROD_W'(di));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            sum_q  <= '0;
            diff_q <= '0;
        end else begin
            v3_q <= v2;
            if (v2) begin
                sum_q  <= sum_d;
                diff_q <= diff_d;
            end
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.sum_out   = sum_q;
    assign bus.diff_out  = diff_q;

endmodule

// File: tb/tb_butterfly_unit.sv
// Directed bench for butterfly_unit: hand-computed vectors, streaming
// against a behavioural model, and asynchronous reset mid-stream.
module tb_butterfly_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    butterfly_unit_if bus ();

    butterfly_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int    ar, ai, br, bi, wr, wi;
        int    sr, si, dr, di;
        string name;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [35:0] pk(int re, int im);
        logic [35:0] r;
        r = {re[17:0], im[17:0]};
        return r;
    endfunction

    function automatic longint sat(longint x);
        if (x > 131071) return 131071;
        if (x < -131072) return -131072;
        return x;
    endfunction

    function automatic longint rs(longint x);
        return (x + 65536) >>> 17;
    endfunction

    function automatic logic [35:0] ref_bf(logic [35:0] a, logic [35:0] b,
                                           logic [35:0] w, bit dif);
        longint ar, ai, br, bi, wr, wi, pr, pi, rr, ri;
        ar = $signed(a[35:18]);
        ai = $signed(a[17:0]);
        br = $signed(b[35:18]);
        bi = $signed(b[17:0]);
        wr = $signed(w[35:18]);
        wi = $signed(w[17:0]);
        pr = sat(rs(br * wr - bi * wi));
        pi = sat(rs(br * wi + bi * wr));
        rr = dif ? sat(ar - pr) : sat(ar + pr);
        ri = dif ? sat(ai - pi) : sat(ai + pi);
        return pk(int'(rr), int'(ri));
    endfunction

    task automatic chk(string nm, logic [35:0] act, logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(vec_t v);
        logic [35:0] a, b, w;
        int lat;
        a = pk(v.ar, v.ai);
        b = pk(v.br, v.bi);
        w = pk(v.wr, v.wi);
        @(negedge clk);
        bus.a_in = a;
        bus.b_in = b;
        bus.twiddle_in = w;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({v.name, " latency"}, 36'(lat), 36'd3);
        chk({v.name, " sum"}, bus.sum_out, pk(v.sr, v.si));
        chk({v.name, " diff"}, bus.diff_out, pk(v.dr, v.di));
        chk({v.name, " model sum"}, ref_bf(a, b, w, 1'b0), pk(v.sr, v.si));
        @(negedge clk);
        chk({v.name, " pulse"}, 36'(bus.out_valid), 36'd0);
    endtask

    logic [35:0] sa[8], sb[8], sw[8];
    logic [35:0] last_sum, last_diff;

    initial begin
        vecs[0] = '{397, 0, 397, 0, 92682, 92682, 678, 281, 116, -281, "diag"};
        vecs[1] = '{397, 0, 397, 0, 131071, 0, 794, 0, 0, 0, "unity"};
        vecs[2] = '{397, 0, 397, 0, -131072, 0, 0, 0, 794, 0, "negunity"};
        vecs[3] = '{131071, 0, 131071, 0, 131071, 0, 131071, 0, 1, 0, "satpos"};
        vecs[4] = '{0, 0, -131072, 0, -131072, 0, 131071, 0, -131071, 0, "prodsat"};
        vecs[5] = '{-131072, 0, 131071, 0, -131072, 0, -131072, 0, -1, 0, "satneg"};
        vecs[6] = '{0, 0, 65536, 0, 1, 0, 1, 0, -1, 0, "halfup"};
        vecs[7] = '{0, 0, -65536, 0, 1, 0, 0, 0, 0, 0, "halfneg"};
        vecs[8] = '{0, 0, 0, 397, 92682, 92682, -281, 281, 281, -281, "imag"};

        bus.in_valid = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.twiddle_in = '0;
        #1;
        chk("reset valid", 36'(bus.out_valid), 36'd0);
        chk("reset sum", bus.sum_out, 36'd0);
        chk("reset diff", bus.diff_out, 36'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        for (int i = 0; i < 8; i++) begin
            sa[i] = pk(100000 - 30000 * i, 7 - 5000 * i);
            sb[i] = pk(-120000 + 33333 * i, 90000 - 25000 * i);
            sw[i] = pk(131071 - 37000 * i, -131072 + 35000 * i);
        end
        last_sum = ref_bf(sa[7], sb[7], sw[7], 1'b0);
        last_diff = ref_bf(sa[7], sb[7], sw[7], 1'b1);

        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k >= 3 && k <= 10) begin
                chk($sformatf("stream valid %0d", k - 3),
                    36'(bus.out_valid), 36'd1);
                chk($sformatf("stream sum %0d", k - 3), bus.sum_out,
                    ref_bf(sa[k-3], sb[k-3], sw[k-3], 1'b0));
                chk($sformatf("stream diff %0d", k - 3), bus.diff_out,
                    ref_bf(sa[k-3], sb[k-3], sw[k-3], 1'b1));
            end else begin
                chk($sformatf("stream idle %0d", k),
                    36'(bus.out_valid), 36'd0);
            end
            if (k >= 11) begin
                chk("gap hold sum", bus.sum_out, last_sum);
                chk("gap hold diff", bus.diff_out, last_diff);
            end
            if (k < 8) begin
                bus.a_in = sa[k];
                bus.b_in = sb[k];
                bus.twiddle_in = sw[k];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
        end

        @(negedge clk);
        bus.a_in = pk(397, 0);
        bus.b_in = pk(397, 0);
        bus.twiddle_in = pk(131071, 0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("midreset valid", 36'(bus.out_valid), 36'd0);
        chk("midreset sum", bus.sum_out, 36'd0);
        chk("midreset diff", bus.diff_out, 36'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("flushed %0d", k), 36'(bus.out_valid), 36'd0);
        end

        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/butterfly_unit.md
Name: butterfly_unit

Overview:
- Radix-2 decimation-in-time FFT butterfly datapath element.
- Computes sum = A + W·B and diff = A − W·B on packed complex operands.
- Fully pipelined; accepts one operand set per clock, with a valid flag travelling alongside the data.
- Instantiated per butterfly lane inside the FFT stage datapath.

Parameters:
- WIDTH, 36, packed complex word width; real part in bits [WIDTH-1:WIDTH/2], imaginary part in bits [WIDTH/2-1:0]. Must be even.
- TW_FRAC, 17, fractional bits of each twiddle component. Twiddle format is signed Q1.17 for WIDTH=36, i.e. TW_FRAC = WIDTH/2 − 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  a_in/b_in/twiddle_in are valid this cycle
- a_in  in  WIDTH  operand A; signed integer real/imag halves
- b_in  in  WIDTH  operand B; same format as A
- twiddle_in  in  WIDTH  twiddle W; signed Q1.17 real/imag halves
- out_valid  out  1  sum_out/diff_out hold a new result
- sum_out  out  WIDTH  signed packed A + W·B
- diff_out  out  WIDTH  signed packed A − W·B

Behaviour:
- Latency is exactly 3 cycles from in_valid sampled high to out_valid high. Throughput is 1 result per cycle; there is no backpressure.
- Stage 1: register a_in, b_in, twiddle_in and in_valid.
- Stage 2: complex multiply P = W·B.
  - Four 18x18 signed products form re = br·wr − bi·wi and im = br·wi + bi·wr at full precision (37 bits).
  - Round half-up: add 2^(TW_FRAC−1), then arithmetic shift right by TW_FRAC.
  - Saturate each part to the signed 18-bit range [−131072, 131071].
  - A is delayed alongside P.
- Stage 3: compute ar±pr and ai±pi at 19 bits, saturate each to 18 bits, and register into sum_out/diff_out.
- A data register loads only when its stage valid is high; otherwise it holds its value. out_valid pulses for exactly the cycles carrying a result.
- Reset (async assert, sync release): all pipeline registers, sum_out, diff_out and out_valid are cleared to 0. Reset mid-stream discards in-flight data; no out_valid is produced for it.
- Boundary cases:
  - W = −1 with B = −131072 yields +131072 internally, which saturates to 131071.
  - W = 131071 (≈1) is used as unity; results follow the rounding rule.
- in_valid held low leaves the outputs unchanged; only out_valid deasserts.

Decomposition:
- Package butterfly_pkg holds:
  - HALF_W = 18 and TW_FRAC = 17
  - typedef cplx_t: packed struct of signed [17:0] re and im, re in the upper half
  - function sat18(): saturates a wider signed value to 18 bits
  - function rnd_shift(): round-half-up arithmetic shift
- One natural sub-module, complex_mult: stage-2 product, round and saturate, with registered output and valid pass-through.
- butterfly_unit owns stage 1, stage 3 and valid alignment.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-stream → sum_out, diff_out and out_valid read 0 immediately; no out_valid for data in flight before the reset.
- Diagonal twiddle: A=397+j0, B=397+j0, W=92682+j92682 (≈0.7071+j0.7071), in_valid for 1 cycle → 3 cycles later out_valid=1 for 1 cycle; sum=678+j281, diff=116−j281.
- Unity twiddle: A=B=397+j0, W=131071+j0 → sum=794+j0, diff=0+j0.
- Negative unity twiddle: W=−131072+j0, A=B=397+j0 → sum=0, diff=794.
- Saturation: A=B=131071+j0, W=131071+j0 → sum=131071 (clamped), diff=1. Then B=−131072, W=−131072 → product saturates to 131071.
- Streaming: 8 back-to-back vectors followed by a gap → 8 consecutive out_valid cycles, in order, each matching a bit-exact reference model. Outputs hold their last value during the gap.
